// File: rtl/apb_quad_enc_pkg.sv
// Shared register map, status bit positions and quadrature step encoding
// for the multi-channel APB quadrature encoder peripheral.
package apb_quad_enc_pkg;

    // Per-channel register offsets within one channel window
    localparam logic [7:0] OFF_COUNT  = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_SNAP   = 8'h08;
    localparam logic [7:0] CH_STRIDE  = 8'h10;

    // Global registers
    localparam logic [7:0] ADDR_CTRL  = 8'h80;
    localparam logic [7:0] ADDR_CMD   = 8'h84;

    // STATUS bit positions
    localparam int ST_DIR = 0;
    localparam int ST_ERR = 1;
    localparam int ST_CHG = 2;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_REV  = 2'd2,
        STEP_ERR  = 2'd3
    } step_t;

    // Classify one transition of the debounced {A,B} pair
    function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
        step_t s;
        case ({prev, cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: s = STEP_FWD;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: s = STEP_REV;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: s = STEP_ERR;
            default:                                s = STEP_NONE;
        endcase
        return s;
    endfunction

    // Byte address of a register inside channel 'ch'
    function automatic logic [7:0] ch_addr(input int ch, input logic [7:0] off);
        return 8'(ch) * CH_STRIDE + off;
    endfunction

endpackage

// File: rtl/quad_enc_channel.sv
// One encoder channel: input synchronisers, tick-based debouncer,
// 4x quadrature decoder, wrapping counter, DIR/ERR/CHG flags and snapshot.
module quad_enc_channel
    import apb_quad_enc_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int DEB_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             enable,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             preload,
    input  logic [CNT_W-1:0] preload_val,
    input  logic             snap_req,
    input  logic [2:0]       w1c,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] snap,
    output logic             dir,
    output logic             err,
    output logic             chg
);

    logic               a_meta_r, a_sync_r, b_meta_r, b_sync_r;
    // The newest sample is not stored: it joins the DEB_LEN-1 stored ones
    logic [DEB_LEN-2:0] hist_a_r, hist_b_r;
    logic [DEB_LEN-1:0] full_a_s, full_b_s;
    logic [1:0]         deb_ab_r, prev_ab_r;
    logic [CNT_W-1:0]   count_r, snap_r;
    logic               dir_r, err_r, chg_r;
    step_t              step_s;
    logic               move_fwd_s, move_rev_s, move_err_s;

    assign full_a_s = {hist_a_r, a_sync_r};
    assign full_b_s = {hist_b_r, b_sync_r};

    // Two-flop synchronisers for the asynchronous encoder pins
    always_ff @(posedge clk) begin
        if (rst) begin
            a_meta_r <= 1'b0;
            a_sync_r <= 1'b0;
            b_meta_r <= 1'b0;
            b_sync_r <= 1'b0;
        end else begin
            a_meta_r <= enc_a;
            a_sync_r <= a_meta_r;
            b_meta_r <= enc_b;
            b_sync_r <= b_meta_r;
        end
    end

    // Debouncer: accept a new level only when the whole sample window agrees
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_a_r <= {(DEB_LEN-1){1'b0}};
            hist_b_r <= {(DEB_LEN-1){1'b0}};
            deb_ab_r <= 2'b00;
        end else if (tick) begin
            hist_a_r <= full_a_s[DEB_LEN-2:0];
            hist_b_r <= full_b_s[DEB_LEN-2:0];
            if (&full_a_s)       deb_ab_r[1] <= 1'b1;
            else if (~|full_a_s) deb_ab_r[1] <= 1'b0;
            if (&full_b_s)       deb_ab_r[0] <= 1'b1;
            else if (~|full_b_s) deb_ab_r[0] <= 1'b0;
        end
    end

    // Previous debounced pair; tracked even when disabled so enabling never steps
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ab_r <= 2'b00;
        end else if (tick) begin
            prev_ab_r <= deb_ab_r;
        end
    end

    // Step classification, only meaningful on a sample tick
    always_comb begin
        step_s = STEP_NONE;
        if (tick) begin
            step_s = decode_step(prev_ab_r, deb_ab_r);
        end else begin
            step_s = STEP_NONE;
        end
    end

    assign move_fwd_s = enable && (step_s == STEP_FWD);
    assign move_rev_s = enable && (step_s == STEP_REV);
    assign move_err_s = enable && (step_s == STEP_ERR);

    // Counter, status flags and snapshot; preload beats a step, set beats W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
            snap_r  <= {CNT_W{1'b0}};
            dir_r   <= 1'b0;
            err_r   <= 1'b0;
            chg_r   <= 1'b0;
        end else begin
            if (preload)         count_r <= preload_val;
            else if (move_fwd_s) count_r <= count_r + CNT_W'(1);
            else if (move_rev_s) count_r <= count_r - CNT_W'(1);

            if (move_fwd_s)      dir_r <= 1'b1;
            else if (move_rev_s) dir_r <= 1'b0;

            if (move_err_s)       err_r <= 1'b1;
            else if (w1c[ST_ERR]) err_r <= 1'b0;

            if (move_fwd_s || move_rev_s) chg_r <= 1'b1;
            else if (w1c[ST_CHG])         chg_r <= 1'b0;

            // Snapshot takes the value held before this cycle's update
            if (snap_req) snap_r <= count_r;
        end
    end

    assign count = count_r;
    assign snap  = snap_r;
    assign dir   = dir_r;
    assign err   = err_r;
    assign chg   = chg_r;

endmodule

// File: rtl/apb_quad_enc_multi.sv
// APB quadrature encoder peripheral: prescaler, register decode, read mux,
// CTRL, level interrupt and NUM_CH encoder channels.
module apb_quad_enc_multi
    import apb_quad_enc_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 32,
    parameter int PRESCALE = 4,
    parameter int DEB_LEN  = 4
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [7:0]        paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [NUM_CH-1:0] enc_a,
    input  logic [NUM_CH-1:0] enc_b,
    output logic              irq
);

    localparam int PS_W = $clog2(PRESCALE);

    logic [PS_W-1:0]   presc_r;
    logic              tick_s;
    logic              wr_s, rd_setup_s, snap_req_s;
    logic [NUM_CH-1:0] ctrl_en_r, ctrl_ie_r;
    logic [NUM_CH-1:0] preload_s;
    logic [2:0]        w1c_s [NUM_CH];
    logic [CNT_W-1:0]  count_arr [NUM_CH];
    logic [CNT_W-1:0]  snap_arr  [NUM_CH];
    logic [NUM_CH-1:0] dir_v, err_v, chg_v;
    logic [31:0]       rd_data_s, prdata_r;
    logic              irq_r;
    logic              unused_pwdata_s;

    assign tick_s     = (presc_r == PS_W'(PRESCALE - 1));
    assign wr_s       = psel & penable & pwrite;
    assign rd_setup_s = psel & ~penable;
    assign snap_req_s = wr_s && (paddr == ADDR_CMD) && pwdata[0];
    assign unused_pwdata_s = ^pwdata;

    // Free-running sample-tick prescaler
    always_ff @(posedge pclk) begin
        if (preset)      presc_r <= {PS_W{1'b0}};
        else if (tick_s) presc_r <= {PS_W{1'b0}};
        else             presc_r <= presc_r + PS_W'(1);
    end

    // Per-channel write strobes decoded from the access phase
    always_comb begin
        preload_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            preload_s[i] = wr_s && (paddr == ch_addr(i, OFF_COUNT));
            w1c_s[i]     = (wr_s && (paddr == ch_addr(i, OFF_STATUS))) ? pwdata[2:0] : 3'b000;
        end
    end

    // Read mux; addresses are disjoint so the hits can be OR-ed together
    always_comb begin
        rd_data_s = (paddr == ADDR_CTRL) ? {16'h0000, 8'(ctrl_ie_r), 8'(ctrl_en_r)} : 32'h0000_0000;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_data_s = rd_data_s
                | ((paddr == ch_addr(i, OFF_COUNT))  ? 32'(count_arr[i]) : 32'h0000_0000)
                | ((paddr == ch_addr(i, OFF_STATUS)) ? {29'd0, chg_v[i], err_v[i], dir_v[i]} : 32'h0000_0000)
                | ((paddr == ch_addr(i, OFF_SNAP))   ? 32'(snap_arr[i])  : 32'h0000_0000);
        end
    end

    // CTRL register; bits for absent channels are never stored
    always_ff @(posedge pclk) begin
        if (preset) begin
            ctrl_en_r <= {NUM_CH{1'b0}};
            ctrl_ie_r <= {NUM_CH{1'b0}};
        end else if (wr_s && (paddr == ADDR_CTRL)) begin
            ctrl_en_r <= pwdata[NUM_CH-1:0];
            ctrl_ie_r <= pwdata[8 +: NUM_CH];
        end
    end

    // Read data captured in the setup phase and held through the access phase
    always_ff @(posedge pclk) begin
        if (preset)          prdata_r <= 32'h0000_0000;
        else if (rd_setup_s) prdata_r <= rd_data_s;
    end

    // Registered level interrupt from enabled change flags
    always_ff @(posedge pclk) begin
        if (preset) irq_r <= 1'b0;
        else        irq_r <= |(chg_v & ctrl_ie_r);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        quad_enc_channel #(
            .CNT_W   (CNT_W),
            .DEB_LEN (DEB_LEN)
        ) u_ch (
            .clk         (pclk),
            .rst         (preset),
            .tick        (tick_s),
            .enable      (ctrl_en_r[g]),
            .enc_a       (enc_a[g]),
            .enc_b       (enc_b[g]),
            .preload     (preload_s[g]),
            .preload_val (pwdata[CNT_W-1:0]),
            .snap_req    (snap_req_s),
            .w1c         (w1c_s[g]),
            .count       (count_arr[g]),
            .snap        (snap_arr[g]),
            .dir         (dir_v[g]),
            .err         (err_v[g]),
            .chg         (chg_v[g])
        );
    end

    assign prdata  = prdata_r;
    assign irq     = irq_r;
    assign pready  = 1'b1;
    assign pslverr = 1'b0;

endmodule
